posit32_encode_pipe: RTL and testbench

- Pipelined posit32 (es=2) encoder. It is the inverse of the decode path: it takes sign, scale, fraction and special flags from the arithmetic units and produces a packed posit32_t word.
- It builds the regime as a run-length field from scale, appends the exponent and fraction, rounds to nearest-even, saturates and applies two's complement for negative values.
- It sits at the output of every posit32 datapath and uses a valid/ready handshake on both sides.

---
 rtl/posit32_encode_pipe.sv | 124 ++++++++++++
 tb/tb_posit32_encode_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit32_encode_pipe.sv
// Two-stage posit32 (es=2) encoder: regime/exponent/fraction assembly, then
// round-to-nearest-even, saturation, negation and special-value selection.
module posit32_encode_pipe #(
  parameter int unsigned FRAC_W  = 28,
  parameter int unsigned SCALE_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [SCALE_W-1:0] in_scale,
  input  logic [FRAC_W-1:0]  in_frac,
  input  logic               in_sticky,
  input  logic               in_zero,
  input  logic               in_nar,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_posit
);

  localparam int unsigned BODY_W = 31;
  // seed = {regime pair, e, frac, pad}; pad keeps shifted-out bits for sticky
  localparam int unsigned V_W    = 2 + 2 + FRAC_W + BODY_W;
  localparam int unsigned LOW_W  = V_W - BODY_W - 1;
  localparam logic signed [SCALE_W-1:0] SCALE_MAX = SCALE_W'(120);
  localparam logic signed [SCALE_W-1:0] SCALE_MIN = SCALE_W'(-120);
  localparam logic [BODY_W-1:0] BODY_MAX = {BODY_W{1'b1}};
  localparam logic [BODY_W-1:0] BODY_MIN = BODY_W'(1);

  typedef struct packed {
    logic              valid;
    logic              sign;
    logic [BODY_W-1:0] body;
    logic              guard;
    logic              sticky;
    logic              sat_hi;
    logic              sat_lo;
    logic              zero;
    logic              nar;
  } s1_t;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: regime as a sign-extending run produced by an arithmetic shift
  logic signed [SCALE_W-1:0] scale_s;
  logic signed [SCALE_W-1:0] k;
  logic                      k_neg;
  logic        [SCALE_W-1:0] sh;
  logic        [V_W-1:0]     v_seed;
  logic        [V_W-1:0]     v;
  s1_t                       s1_c;
  s1_t                       s1_q;

  assign scale_s = $signed(in_scale);
  assign k       = scale_s >>> 2;
  assign k_neg   = k[SCALE_W-1];
  assign sh      = k_neg ? ~k : k;
  assign v_seed  = {~k_neg, k_neg, in_scale[1:0], in_frac, {BODY_W{1'b0}}};
  assign v       = $unsigned($signed(v_seed) >>> sh);

  always_comb begin
    s1_c        = '0;
    s1_c.valid  = in_valid;
    s1_c.sign   = in_sign;
    s1_c.body   = v[V_W-1 -: BODY_W];
    s1_c.guard  = v[LOW_W];
    s1_c.sticky = (|v[LOW_W-1:0]) | in_sticky;
    s1_c.sat_hi = scale_s > SCALE_MAX;
    s1_c.sat_lo = scale_s < SCALE_MIN;
    s1_c.zero   = in_zero;
    s1_c.nar    = in_nar;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else if (en) begin
      s1_q <= s1_c;
    end
  end

  // Stage 2: RNE, clamp to [1, max], two's complement, specials
  logic              round_up;
  logic [31:0]       rnd;
  logic [BODY_W-1:0] body_fin;
  logic [31:0]       mag;
  logic [31:0]       posit_c;

  assign round_up = s1_q.guard && (s1_q.body[0] || s1_q.sticky);
  assign rnd      = {1'b0, s1_q.body} + 32'(round_up);

  always_comb begin
    body_fin = rnd[BODY_W-1:0];
    if (s1_q.sat_hi || rnd[31]) begin
      body_fin = BODY_MAX;
    end else if (s1_q.sat_lo || (rnd[BODY_W-1:0] == '0)) begin
      body_fin = BODY_MIN;
    end
  end

  always_comb begin
    mag     = {1'b0, body_fin};
    posit_c = s1_q.sign ? (32'd0 - mag) : mag;
    if (s1_q.nar) begin
      posit_c = 32'h8000_0000;
    end else if (s1_q.zero) begin
      posit_c = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= 32'h0;
    end else if (en) begin
      out_valid <= s1_q.valid;
      out_posit <= posit_c;
    end
  end

endmodule

// File: tb/tb_posit32_encode_pipe.sv
// Bench for posit32_encode_pipe: spec vectors, latency, backpressure, reset and
// randomized traffic against a bit-list reference model.
module tb_posit32_encode_pipe;

  localparam int unsigned FRAC_W  = 28;
  localparam int unsigned SCALE_W = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [SCALE_W-1:0] in_scale;
  logic [FRAC_W-1:0]  in_frac;
  logic               in_sticky;
  logic               in_zero;
  logic               in_nar;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_posit;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  posit32_encode_pipe #(.FRAC_W(FRAC_W), .SCALE_W(SCALE_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_scale(in_scale), .in_frac(in_frac),
    .in_sticky(in_sticky), .in_zero(in_zero), .in_nar(in_nar),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  typedef struct {
    string       name;
    logic        sign;
    int          scale;
    logic [27:0] frac;
    logic        sticky;
    logic        zero;
    logic        nar;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  // Reference: list the posit bits one by one, then cut body/guard/sticky
  function automatic logic [31:0] ref_posit(logic s, int sc, logic [27:0] f,
                                            logic st, logic z, logic n);
    int     k;
    int     e;
    longint body;
    bit     bits[$];
    logic   guard;
    logic   stk;
    if (n) return 32'h8000_0000;
    if (z) return 32'h0;
    if (sc > 120) begin
      body = 64'h7FFF_FFFF;
    end else if (sc < -120) begin
      body = 1;
    end else begin
      k = (sc >= 0) ? sc / 4 : -((3 - sc) / 4);
      e = sc - 4 * k;
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(e[1]);
      bits.push_back(e[0]);
      for (int i = 27; i >= 0; i--) bits.push_back(f[i]);
      body = 0;
      for (int i = 0; i < 31; i++)
        body = body * 2 + ((i < bits.size()) ? longint'(bits[i]) : 64'd0);
      guard = (bits.size() > 31) ? bits[31] : 1'b0;
      stk = st;
      for (int i = 32; i < bits.size(); i++) stk = stk | bits[i];
      if (guard && ((body % 2) == 1 || stk)) body = body + 1;
      if (body > 64'h7FFF_FFFF) body = 64'h7FFF_FFFF;
      if (body < 1) body = 1;
    end
    return s ? 32'(-body) : 32'(body);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic set_inputs(logic s, int sc, logic [27:0] f, logic st, logic z, logic n);
    in_sign   = s;
    in_scale  = SCALE_W'(sc);
    in_frac   = f;
    in_sticky = st;
    in_zero   = z;
    in_nar    = n;
  endtask

  task automatic rand_inputs();
    set_inputs(1'(($urandom)), int'($urandom_range(0, 280)) - 140, 28'($urandom),
               1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
  endtask

  function automatic logic [31:0] ref_cur();
    return ref_posit(in_sign, int'($signed(in_scale)), in_frac, in_sticky, in_zero, in_nar);
  endfunction

  // Single word into an empty pipe: not visible after 1 edge, visible after 2
  task automatic apply_vec(vec_t v);
    set_inputs(v.sign, v.scale, v.frac, v.sticky, v.zero, v.nar);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rand_inputs();
    check({v.name, "_valid_n1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({v.name, "_valid_n2"}, 32'(out_valid), 32'd1);
    check(v.name, out_posit, v.exp);
    @(posedge clk); #1;
  endtask

  // One cycle of scoreboarded traffic; inputs are already driven
  task automatic step();
    #1;
    if (out_valid && out_ready) begin
      pops++;
      if (sb_q.size() == 0) check("stream_extra", out_posit, 32'hxxxx_xxxx);
      else check("stream", out_posit, sb_q.pop_front());
    end
    if (in_valid && in_ready) sb_q.push_back(ref_cur());
    @(posedge clk); #1;
  endtask

  task automatic drain(string nm);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    check({nm, "_drained"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    vecs[0]  = '{"one",        0,    0, 28'h0,       0, 0, 0, 32'h4000_0000};
    vecs[1]  = '{"sixteen",    0,    4, 28'h0,       0, 0, 0, 32'h6000_0000};
    vecs[2]  = '{"half",       0,   -1, 28'h0,       0, 0, 0, 32'h3800_0000};
    vecs[3]  = '{"one_5",      0,    0, 28'h800_0000, 0, 0, 0, 32'h4400_0000};
    vecs[4]  = '{"neg_one",    1,    0, 28'h0,       0, 0, 0, 32'hC000_0000};
    vecs[5]  = '{"tie_even",   0,    0, 28'h000_0001, 0, 0, 0, 32'h4000_0000};
    vecs[6]  = '{"tie_odd",    0,    0, 28'h000_0003, 0, 0, 0, 32'h4000_0002};
    vecs[7]  = '{"sticky_up",  0,    0, 28'h000_0001, 1, 0, 0, 32'h4000_0001};
    vecs[8]  = '{"sat_hi",     0,  200, 28'h0,       0, 0, 0, 32'h7FFF_FFFF};
    vecs[9]  = '{"sat_lo",     0, -200, 28'h0,       0, 0, 0, 32'h0000_0001};
    vecs[10] = '{"sat_lo_neg", 1, -200, 28'h0,       0, 0, 0, 32'hFFFF_FFFF};
    vecs[11] = '{"max_120",    0,  120, 28'h0,       0, 0, 0, 32'h7FFF_FFFF};
    vecs[12] = '{"min_m120",   0, -120, 28'h0,       0, 0, 0, 32'h0000_0001};
    vecs[13] = '{"nar_zero",   1,   37, 28'h123_4567, 0, 1, 1, 32'h8000_0000};
    vecs[14] = '{"zero_neg",   1,   -5, 28'hABC_DEF0, 1, 1, 0, 32'h0000_0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_inputs(0, 0, 28'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_posit", out_posit, 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Backpressure: 5 words, out_ready low for 3 cycles mid-stream
    begin
      int sent = 0;
      logic [31:0] held = 32'h0;
      pops = 0;
      rand_inputs();
      for (int c = 0; c < 12; c++) begin
        in_valid  = (sent < 5);
        out_ready = !(c >= 3 && c <= 5);
        #1;
        if (!out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          if (c == 3) held = out_posit;
          else check("stall_hold", out_posit, held);
          check("stall_valid", 32'(out_valid), 32'd1);
        end
        if (in_valid && in_ready) sent++;
        step();
        rand_inputs();
      end
      drain("bp");
      check("bp_count", 32'(pops), 32'd5);
    end

    // Full throughput: one word per cycle with out_ready held high
    begin
      pops = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
        rand_inputs();
        in_valid = 1'b1;
        #1;
        check("tput_in_ready", 32'(in_ready), 32'd1);
        step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("tput_count", 32'(pops), 32'd10);
      drain("tput");
    end

    // Reset with two words in flight
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rand_inputs();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_posit", out_posit, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_flushed", 32'(out_valid), 32'd0);
    end
    apply_vec(vecs[3]);

    // Random traffic with random stalls and bubbles
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
